// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-slot TDM link, used by both the
// transmit-side scanner and the receive-side demux.
package tdm_pkg;

    localparam int SLOTS = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        HUNT,
        RUN
    } state_t;

    // Cycle counter width; a single-cycle slot still keeps one bit.
    function automatic int cyc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_demux8_if.sv
// Serial-side and frame-side signals of the TDM receiver.
interface tdm_demux8_if;
    import tdm_pkg::*;

    logic             en;
    logic             din;
    logic             sync;
    logic [SEL_W-1:0] sel;
    logic [SLOTS-1:0] dout;
    logic             dout_valid;
    logic             frame_err;

    modport master (
        output en, din, sync,
        input  sel, dout, dout_valid, frame_err
    );

    modport slave (
        input  en, din, sync,
        output sel, dout, dout_valid, frame_err
    );

endinterface

// File: rtl/tdm_slot_counter.sv
// Cycle-within-slot and slot counters; a restart makes the current
// cycle slot 0, cycle 0 and processes it as such.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int SLOT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             restart,
    output logic [SEL_W-1:0] slot,
    output logic             at_start,
    output logic             sample,
    output logic [SEL_W-1:0] sample_slot
);

    localparam int CW = cyc_width(SLOT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);

    logic [CW-1:0]    cyc;
    logic [CW-1:0]    cyc_e;
    logic [SEL_W-1:0] slot_e;

    // Effective position of this cycle after a possible restart.
    always_comb begin
        cyc_e  = restart ? '0 : cyc;
        slot_e = restart ? '0 : slot;
    end

    assign at_start    = (slot == '0) && (cyc == '0);
    assign sample      = adv && (cyc_e == LAST);
    assign sample_slot = slot_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc  <= '0;
            slot <= '0;
        end else if (adv) begin
            if (cyc_e == LAST) begin
                cyc  <= '0;
                slot <= slot_e + SEL_W'(1);
            end else begin
                cyc  <= cyc_e + CW'(1);
                slot <= slot_e;
            end
        end
    end

endmodule

// File: rtl/tdm_demux8.sv
// Receive side of the 8-slot TDM link: sync alignment, slot sampling
// and frame reassembly with valid and misalignment strobes.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int SLOT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux8_if.slave  bus
);

    state_t           state;
    state_t           state_d;
    logic [SLOTS-1:0] asm_q;
    logic [SLOTS-1:0] asm_d;
    logic [SLOTS-1:0] dout_q;
    logic [SLOTS-1:0] dout_d;
    logic             valid_q;
    logic             valid_d;
    logic             err_q;
    logic             err_d;
    logic             adv;
    logic             restart;
    logic             misalign;
    logic             at_start;
    logic             sample;
    logic [SEL_W-1:0] slot;
    logic [SEL_W-1:0] sample_slot;

    assign misalign = (state == RUN) && !at_start;
    assign restart  = bus.en && bus.sync && ((state == HUNT) || misalign);
    assign adv      = bus.en && ((state == RUN) || bus.sync);

    tdm_slot_counter #(
        .SLOT_CYCLES (SLOT_CYCLES)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .adv         (adv),
        .restart     (restart),
        .slot        (slot),
        .at_start    (at_start),
        .sample      (sample),
        .sample_slot (sample_slot)
    );

    always_comb begin
        state_d = state;
        asm_d   = asm_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (restart) begin
            state_d = RUN;
            asm_d   = '0;
            err_d   = (state == RUN);
        end
        // A restart forces slot 0, so completion never meets an error.
        if (sample) begin
            asm_d[sample_slot] = bus.din;
            if (sample_slot == SEL_W'(SLOTS - 1)) begin
                dout_d  = asm_d;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HUNT;
            asm_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            asm_q   <= asm_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.sel        = (state == RUN) ? slot : '0;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8 at SLOT_CYCLES=1 and 4 against a
// position-in-frame reference model.
module tb_tdm_demux8;
    import tdm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tdm_demux8_if bus1 ();
    tdm_demux8_if bus4 ();

    tdm_demux8 #(.SLOT_CYCLES(1)) u1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1)
    );
    tdm_demux8 #(.SLOT_CYCLES(4)) u4 (
        .clk (clk), .rst_n (rst_n), .bus (bus4)
    );

    int checks = 0;
    int errors = 0;

    int       np[2] = '{1, 4};
    bit       al[2];
    int       pos[2];
    bit [7:0] bits[2];
    bit [7:0] e_dout[2];
    bit       e_val[2];
    bit       e_err[2];
    bit [2:0] e_sel[2];

    // pos = enabled cycles since frame start; slot = pos / N.
    task automatic model(input int k, input bit e, input bit s, input bit d);
        int n = np[k];
        e_val[k] = 1'b0;
        e_err[k] = 1'b0;
        if (e) begin
            if (s && (!al[k] || pos[k] != 0)) begin
                e_err[k] = al[k];
                al[k]    = 1'b1;
                pos[k]   = 0;
                bits[k]  = '0;
            end
            if (al[k]) begin
                if (pos[k] % n == n - 1) bits[k][3'(pos[k] / n)] = d;
                if (pos[k] == 8 * n - 1) begin
                    e_val[k]  = 1'b1;
                    e_dout[k] = bits[k];
                end
                pos[k] = (pos[k] + 1) % (8 * n);
            end
        end
        e_sel[k] = al[k] ? 3'(pos[k] / n) : 3'd0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            al[k] = 1'b0; pos[k] = 0; bits[k] = '0; e_dout[k] = '0;
            e_val[k] = 1'b0; e_err[k] = 1'b0; e_sel[k] = '0;
        end
    endtask

    task automatic obs(input int k, output logic [7:0] d, output logic v,
                       output logic r, output logic [2:0] s);
        if (k == 0) begin
            d = bus1.dout; v = bus1.dout_valid; r = bus1.frame_err; s = bus1.sel;
        end else begin
            d = bus4.dout; v = bus4.dout_valid; r = bus4.frame_err; s = bus4.sel;
        end
    endtask

    task automatic tick2(input bit e0, input bit s0, input bit d0,
                         input bit e1, input bit s1, input bit d1);
        bus1.en = e0; bus1.sync = s0; bus1.din = d0;
        bus4.en = e1; bus4.sync = s1; bus4.din = d1;
        model(0, e0, s0, d0);
        model(1, e1, s1, d1);
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int k, input bit e, input bit s, input bit d);
        if (k == 0) tick2(e, s, d, 1'b0, 1'b0, 1'($urandom));
        else        tick2(1'b0, 1'b0, 1'($urandom), e, s, d);
    endtask

    task automatic test_reset();
        logic [7:0] od; logic ov, oe; logic [2:0] os;
        rst_n = 1'b0;
        bus1.en = 1'b1; bus1.sync = 1'b1; bus1.din = 1'b1;
        bus4.en = 1'b1; bus4.sync = 1'b1; bus4.din = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            obs(k, od, ov, oe, os);
            checks += 4;
            if (od !== 8'h00) begin errors++; $display("FAIL reset_dout[%0d]: got %h want 00", k, od); end
            if (ov !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", k, ov); end
            if (oe !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b want 0", k, oe); end
            if (os !== 3'd0) begin errors++; $display("FAIL reset_sel[%0d]: got %0d want 0", k, os); end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_frame_a5();
        logic [7:0] od; logic ov, oe; logic [2:0] os;
        bit [7:0] pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            tick(0, 1'b1, i == 0, pat[3'(i)]);
            obs(0, od, ov, oe, os);
            checks += 2;
            if (os !== e_sel[0]) begin errors++; $display("FAIL a5_sel c%0d: got %0d want %0d", i, os, e_sel[0]); end
            if (ov !== e_val[0]) begin errors++; $display("FAIL a5_valid c%0d: got %b want %b", i, ov, e_val[0]); end
        end
        checks += 2;
        if (od !== 8'hA5) begin errors++; $display("FAIL a5_dout: got %h want a5", od); end
        if (ov !== 1'b1) begin errors++; $display("FAIL a5_valid_end: got %b want 1", ov); end
    endtask

    task automatic test_free_run();
        logic [7:0] od; logic ov, oe; logic [2:0] os;
        for (int i = 0; i < 8; i++) begin
            tick(0, 1'b1, 1'b0, 1'b1);
            obs(0, od, ov, oe, os);
            checks += 3;
            if (oe !== 1'b0) begin errors++; $display("FAIL ff_err c%0d: got %b want 0", i, oe); end
            if (ov !== e_val[0]) begin errors++; $display("FAIL ff_valid c%0d: got %b want %b", i, ov, e_val[0]); end
            if (os !== e_sel[0]) begin errors++; $display("FAIL ff_sel c%0d: got %0d want %0d", i, os, e_sel[0]); end
        end
        checks++;
        if (od !== 8'hFF) begin errors++; $display("FAIL ff_dout: got %h want ff", od); end
    endtask

    task automatic test_misaligned_sync();
        logic [7:0] od; logic ov, oe; logic [2:0] os;
        bit [7:0] pat = 8'h3C;
        for (int i = 0; i < 3; i++) tick(0, 1'b1, 1'b0, 1'($urandom));
        for (int i = 0; i < 8; i++) begin
            tick(0, 1'b1, i == 0, pat[3'(i)]);
            obs(0, od, ov, oe, os);
            checks += 3;
            if (oe !== e_err[0]) begin errors++; $display("FAIL mis_err c%0d: got %b want %b", i, oe, e_err[0]); end
            if (ov !== e_val[0]) begin errors++; $display("FAIL mis_valid c%0d: got %b want %b", i, ov, e_val[0]); end
            if (od !== e_dout[0]) begin errors++; $display("FAIL mis_dout c%0d: got %h want %h", i, od, e_dout[0]); end
            if (i == 0) begin
                checks += 2;
                if (oe !== 1'b1) begin errors++; $display("FAIL mis_err_pulse: got %b want 1", oe); end
                if (od !== 8'hFF) begin errors++; $display("FAIL mis_dout_hold: got %h want ff", od); end
            end
        end
        checks++;
        if (od !== 8'h3C) begin errors++; $display("FAIL mis_dout_end: got %h want 3c", od); end
    endtask

    task automatic test_slot4x();
        logic [7:0] od; logic ov, oe; logic [2:0] os;
        bit [7:0] pat = 8'h81;
        bit d;
        for (int c = 0; c < 32; c++) begin
            d = (c % 4 == 3) ? pat[3'(c / 4)] : 1'($urandom);
            tick(1, 1'b1, c == 0, d);
            obs(1, od, ov, oe, os);
            checks += 2;
            if (ov !== e_val[1]) begin errors++; $display("FAIL x4_valid c%0d: got %b want %b", c, ov, e_val[1]); end
            if (os !== e_sel[1]) begin errors++; $display("FAIL x4_sel c%0d: got %0d want %0d", c, os, e_sel[1]); end
        end
        checks += 2;
        if (od !== 8'h81) begin errors++; $display("FAIL x4_dout: got %h want 81", od); end
        if (ov !== 1'b1) begin errors++; $display("FAIL x4_valid_end: got %b want 1", ov); end
    endtask

    task automatic test_enable();
        logic [7:0] od; logic ov, oe; logic [2:0] os;
        bit [7:0] pat = 8'h5A;
        for (int i = 0; i < 4; i++) tick(0, 1'b1, i == 0, pat[3'(i)]);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1'b0, 1'($urandom), 1'($urandom));
            obs(0, od, ov, oe, os);
            checks += 3;
            if (os !== 3'd4) begin errors++; $display("FAIL en_sel_hold c%0d: got %0d want 4", i, os); end
            if (ov !== 1'b0) begin errors++; $display("FAIL en_valid c%0d: got %b want 0", i, ov); end
            if (oe !== 1'b0) begin errors++; $display("FAIL en_err c%0d: got %b want 0", i, oe); end
        end
        for (int i = 4; i < 8; i++) tick(0, 1'b1, 1'b0, pat[3'(i)]);
        obs(0, od, ov, oe, os);
        checks += 2;
        if (od !== 8'h5A) begin errors++; $display("FAIL en_dout: got %h want 5a", od); end
        if (ov !== 1'b1) begin errors++; $display("FAIL en_valid_end: got %b want 1", ov); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] od; logic ov, oe; logic [2:0] os;
        bit [7:0] pat = 8'hC3;
        for (int i = 0; i < 5; i++) tick(0, 1'b1, i == 0, pat[3'(i)]);
        rst_n = 1'b0;
        model_reset();
        #1;
        obs(0, od, ov, oe, os);
        checks += 3;
        if (od !== 8'h00) begin errors++; $display("FAIL rmid_dout: got %h want 00", od); end
        if (os !== 3'd0) begin errors++; $display("FAIL rmid_sel: got %0d want 0", os); end
        if (ov !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", ov); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(0, 1'b1, 1'b0, 1'($urandom));
            obs(0, od, ov, oe, os);
            checks += 2;
            if (ov !== 1'b0) begin errors++; $display("FAIL hunt_valid c%0d: got %b want 0", i, ov); end
            if (os !== 3'd0) begin errors++; $display("FAIL hunt_sel c%0d: got %0d want 0", i, os); end
        end
        for (int i = 0; i < 8; i++) tick(0, 1'b1, i == 0, pat[3'(i)]);
        obs(0, od, ov, oe, os);
        checks += 2;
        if (od !== 8'hC3) begin errors++; $display("FAIL rmid_dout_end: got %h want c3", od); end
        if (ov !== 1'b1) begin errors++; $display("FAIL rmid_valid_end: got %b want 1", ov); end
    endtask

    task automatic test_random();
        logic [7:0] od; logic ov, oe; logic [2:0] os;
        for (int c = 0; c < 800; c++) begin
            tick2(($urandom % 6) != 0, ($urandom % 40) == 0, 1'($urandom),
                  ($urandom % 6) != 0, ($urandom % 90) == 0, 1'($urandom));
            for (int k = 0; k < 2; k++) begin
                obs(k, od, ov, oe, os);
                checks += 4;
                if (od !== e_dout[k]) begin errors++; $display("FAIL rnd_dout[%0d] c%0d: got %h want %h", k, c, od, e_dout[k]); end
                if (ov !== e_val[k]) begin errors++; $display("FAIL rnd_valid[%0d] c%0d: got %b want %b", k, c, ov, e_val[k]); end
                if (oe !== e_err[k]) begin errors++; $display("FAIL rnd_err[%0d] c%0d: got %b want %b", k, c, oe, e_err[k]); end
                if (os !== e_sel[k]) begin errors++; $display("FAIL rnd_sel[%0d] c%0d: got %0d want %0d", k, c, os, e_sel[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_free_run();
        test_misaligned_sync();
        test_slot4x();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
